// File: rtl/fmc_req_queue_if.sv
// Request/bus/response signal bundle between the FMC front end, the request queue and the peripheral bus.
// The queue uses the slave view; the environment driving it uses the master view.
interface fmc_req_queue_if #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 16
);
  logic                 req_valid_i;
  logic                 req_write_i;
  logic [AddrWidth-1:0] req_addr_i;
  logic [DataWidth-1:0] req_wdata_i;
  logic                 req_ready_o;
  logic                 bus_valid_o;
  logic                 bus_write_o;
  logic [AddrWidth-1:0] bus_addr_o;
  logic [DataWidth-1:0] bus_wdata_o;
  logic                 bus_ready_i;
  logic                 rsp_valid_i;
  logic [DataWidth-1:0] rsp_rdata_i;
  logic                 rd_valid_o;
  logic [DataWidth-1:0] rd_data_o;
  logic                 wait_o;
  logic                 err_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    output req_ready_o,
    output bus_valid_o, bus_write_o, bus_addr_o, bus_wdata_o,
    input  bus_ready_i,
    input  rsp_valid_i, rsp_rdata_i,
    output rd_valid_o, rd_data_o, wait_o, err_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
    input  req_ready_o,
    input  bus_valid_o, bus_write_o, bus_addr_o, bus_wdata_o,
    output bus_ready_i,
    output rsp_valid_i, rsp_rdata_i,
    input  rd_valid_o, rd_data_o, wait_o, err_o
  );
endinterface

// File: rtl/fmc_req_queue.sv
// In-order request queue between the FMC PSRAM front end and the peripheral bus,
// with a single outstanding read and read-data return to the front end.
module fmc_req_queue #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 4
) (
  input logic            clk_i,
  input logic            rst_ni,
  fmc_req_queue_if.slave bus_if
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic                 mem_write_q [Depth];
  logic                 mem_write_d [Depth];
  logic [AddrWidth-1:0] mem_addr_q  [Depth];
  logic [AddrWidth-1:0] mem_addr_d  [Depth];
  logic [DataWidth-1:0] mem_wdata_q [Depth];
  logic [DataWidth-1:0] mem_wdata_d [Depth];

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 rd_outstanding_q, rd_outstanding_d;
  logic                 bus_rd_pending_q, bus_rd_pending_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DataWidth-1:0] rd_data_q, rd_data_d;
  logic                 err_q, err_d;

  logic full, head_write, bus_valid, push, pop, rsp_ok;

  always_comb begin
    full       = (count_q == CntW'(Depth));
    head_write = mem_write_q[rd_ptr_q];
    // A read head is held back while the previous read still awaits its response.
    bus_valid  = (count_q != '0) && !(!head_write && bus_rd_pending_q);
    push       = bus_if.req_valid_i && !full && !rd_outstanding_q;
    pop        = bus_valid && bus_if.bus_ready_i;
    // Only a read popped on an earlier edge can own a response.
    rsp_ok     = bus_if.rsp_valid_i && bus_rd_pending_q;
  end

  assign bus_if.req_ready_o = !full && !rd_outstanding_q;
  assign bus_if.bus_valid_o = bus_valid;
  assign bus_if.bus_write_o = head_write;
  assign bus_if.bus_addr_o  = mem_addr_q[rd_ptr_q];
  assign bus_if.bus_wdata_o = mem_wdata_q[rd_ptr_q];
  assign bus_if.rd_valid_o  = rd_valid_q;
  assign bus_if.rd_data_o   = rd_data_q;
  assign bus_if.wait_o      = full || rd_outstanding_q;
  assign bus_if.err_o       = err_q;

  always_comb begin
    mem_write_d      = mem_write_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    rd_outstanding_d = rd_outstanding_q;
    bus_rd_pending_d = bus_rd_pending_q;
    rd_valid_d       = rsp_ok;
    rd_data_d        = rd_data_q;
    err_d            = err_q || (bus_if.rsp_valid_i && !bus_rd_pending_q);

    if (push) begin
      mem_write_d[wr_ptr_q] = bus_if.req_write_i;
      mem_addr_d[wr_ptr_q]  = bus_if.req_addr_i;
      mem_wdata_d[wr_ptr_q] = bus_if.req_wdata_i;
      wr_ptr_d              = wr_ptr_q + PtrW'(1);
      if (!bus_if.req_write_i) rd_outstanding_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (!head_write) bus_rd_pending_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (rsp_ok) begin
      rd_data_d        = bus_if.rsp_rdata_i;
      rd_outstanding_d = 1'b0;
      bus_rd_pending_d = 1'b0;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_write_q <= mem_write_d;
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      rd_outstanding_q <= 1'b0;
      bus_rd_pending_q <= 1'b0;
      rd_valid_q       <= 1'b0;
      rd_data_q        <= '0;
      err_q            <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      rd_outstanding_q <= rd_outstanding_d;
      bus_rd_pending_q <= bus_rd_pending_d;
      rd_valid_q       <= rd_valid_d;
      rd_data_q        <= rd_data_d;
      err_q            <= err_d;
    end
  end
endmodule

// File: tb/tb_fmc_req_queue.sv
// Self-checking bench for fmc_req_queue: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fmc_req_queue;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   chk_en;

  fmc_req_queue_if #(.AddrWidth(AW), .DataWidth(DW)) bif ();

  fmc_req_queue #(.AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  bit            m_out;
  bit            m_pend;
  bit            m_rdv;
  bit            m_err;
  logic [DW-1:0] m_rdata;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && !m_out;
  endfunction

  function automatic bit m_bvalid();
    return (mq.size() != 0) && !(!mq[0].w && m_pend);
  endfunction

  // Reference model: advances on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    bit   push, pop, ok, spur;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_out = 0; m_pend = 0; m_rdv = 0; m_err = 0; m_rdata = '0;
    end else begin
      push = bif.req_valid_i && m_ready();
      pop  = m_bvalid() && bif.bus_ready_i;
      ok   = bif.rsp_valid_i && m_pend;
      spur = bif.rsp_valid_i && !m_pend;
      m_rdv = ok;
      if (ok) begin
        m_rdata = bif.rsp_rdata_i;
        m_pend  = 0;
        m_out   = 0;
      end
      if (spur) m_err = 1;
      if (pop) begin
        e = mq.pop_front();
        if (!e.w) m_pend = 1;
      end
      if (push) begin
        e.w = bif.req_write_i; e.a = bif.req_addr_i; e.d = bif.req_wdata_i;
        mq.push_back(e);
        if (!e.w) m_out = 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(bif.req_ready_o), 32'(m_ready()));
      chk("bus_valid", 32'(bif.bus_valid_o), 32'(m_bvalid()));
      chk("wait",      32'(bif.wait_o),      32'((mq.size() == DEPTH) || m_out));
      chk("err",       32'(bif.err_o),       32'(m_err));
      chk("rd_valid",  32'(bif.rd_valid_o),  32'(m_rdv));
      chk("rd_data",   32'(bif.rd_data_o),   32'(m_rdata));
      if (m_bvalid()) begin
        chk("bus_write", 32'(bif.bus_write_o), 32'(mq[0].w));
        chk("bus_addr",  32'(bif.bus_addr_o),  32'(mq[0].a));
        chk("bus_wdata", 32'(bif.bus_wdata_o), 32'(mq[0].d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.req_valid_i = 0; bif.req_write_i = 0; bif.req_addr_i = '0; bif.req_wdata_i = '0;
    bif.bus_ready_i = 0; bif.rsp_valid_i = 0; bif.rsp_rdata_i = '0;
  endtask

  task automatic drive_req(bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    bif.req_valid_i = 1; bif.req_write_i = w; bif.req_addr_i = a; bif.req_wdata_i = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bif.req_valid_i = 0;
    bif.bus_ready_i = 1;
    while (bif.bus_valid_o && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(bif.bus_valid_o), 32'h0);
    bif.bus_ready_i = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    tests = 0; fails = 0; chk_en = 0;
    idle();
    rst_n = 0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bif.req_valid_i = 1'($urandom); bif.req_write_i = 1'($urandom);
      bif.req_addr_i = AW'($urandom); bif.req_wdata_i = DW'($urandom);
      bif.bus_ready_i = 1'($urandom); bif.rsp_valid_i = 1'($urandom);
      bif.rsp_rdata_i = DW'($urandom);
      tick();
      chk_en = 1;
    end
    idle();
    chk("rst_bus_valid", 32'(bif.bus_valid_o), 32'h0);
    chk("rst_rd_valid",  32'(bif.rd_valid_o),  32'h0);
    chk("rst_err",       32'(bif.err_o),       32'h0);
    chk("rst_wait",      32'(bif.wait_o),      32'h0);
    chk("rst_ready",     32'(bif.req_ready_o), 32'h1);
    chk("rst_rd_data",   32'(bif.rd_data_o),   32'h0);
    rst_n = 1;
    tick();

    // Fill with four writes, no pops
    for (int i = 0; i < 4; i++) begin
      drive_req(1, AW'(16'h10 + i), DW'(16'hA0 + i));
      tick();
    end
    bif.req_valid_i = 0;
    chk("full_wait",  32'(bif.wait_o),      32'h1);
    chk("full_ready", 32'(bif.req_ready_o), 32'h0);
    chk("full_model", 32'(mq.size()),       32'd4);
    bif.bus_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk("pop_valid", 32'(bif.bus_valid_o), 32'h1);
      chk("pop_addr",  32'(bif.bus_addr_o),  32'h10 + 32'(i));
      chk("pop_wdata", 32'(bif.bus_wdata_o), 32'hA0 + 32'(i));
      tick();
      if (i == 0) chk("wait_after_pop", 32'(bif.wait_o), 32'h0);
    end
    bif.bus_ready_i = 0;
    chk("empty_after_pops", 32'(bif.bus_valid_o), 32'h0);

    // Pointer wrap: ten writes with toggling bus_ready
    k = 0; n = 0;
    while (k < 10 && n < 100) begin
      drive_req(1, AW'(16'h30 + k), DW'(16'hC0 + k));
      bif.bus_ready_i = ~bif.bus_ready_i;
      if (bif.req_ready_o) k++;
      tick();
      n++;
    end
    chk("wrap_accepted", 32'(k), 32'd10);
    drain();

    // Read ordered behind a write
    drive_req(1, 16'h20, 16'h5555);
    tick();
    drive_req(0, 16'h20, 16'h0);
    tick();
    bif.req_valid_i = 0;
    chk("rd_acc_wait",  32'(bif.wait_o),      32'h1);
    chk("rd_acc_ready", 32'(bif.req_ready_o), 32'h0);
    chk("rd_head_is_wr", 32'(bif.bus_write_o), 32'h1);
    bif.bus_ready_i = 1;
    tick();
    chk("rd_head_valid", 32'(bif.bus_valid_o), 32'h1);
    chk("rd_head_is_rd", 32'(bif.bus_write_o), 32'h0);
    chk("rd_head_addr",  32'(bif.bus_addr_o),  32'h20);
    tick();
    bif.bus_ready_i = 0;
    chk("rd_popped", 32'(bif.bus_valid_o), 32'h0);
    tick();
    bif.rsp_valid_i = 1; bif.rsp_rdata_i = 16'h5555;
    tick();
    bif.rsp_valid_i = 0; bif.rsp_rdata_i = '0;
    chk("rd_valid_strobe", 32'(bif.rd_valid_o),  32'h1);
    chk("rd_data_val",     32'(bif.rd_data_o),   32'h5555);
    chk("rd_done_wait",    32'(bif.wait_o),      32'h0);
    chk("rd_done_ready",   32'(bif.req_ready_o), 32'h1);
    tick();
    chk("rd_valid_pulse", 32'(bif.rd_valid_o), 32'h0);
    chk("rd_data_held",   32'(bif.rd_data_o),  32'h5555);

    // Simultaneous push and pop at count 2
    drive_req(1, 16'h40, 16'h1); tick();
    drive_req(1, 16'h41, 16'h2); tick();
    drive_req(1, 16'h42, 16'h3); bif.bus_ready_i = 1; tick();
    bif.bus_ready_i = 0;
    chk("pp_head", 32'(bif.bus_addr_o), 32'h41);
    drive_req(1, 16'h43, 16'h4); tick();
    chk("pp_not_full", 32'(bif.req_ready_o), 32'h1);
    drive_req(1, 16'h44, 16'h5); tick();
    bif.req_valid_i = 0;
    chk("pp_full", 32'(bif.req_ready_o), 32'h0);
    bif.bus_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", 32'(bif.bus_addr_o), 32'h41 + 32'(i));
      tick();
    end
    bif.bus_ready_i = 0;

    // Spurious response, then reset during an outstanding read
    bif.rsp_valid_i = 1; bif.rsp_rdata_i = 16'hDEAD;
    tick();
    bif.rsp_valid_i = 0;
    chk("spur_err",      32'(bif.err_o),      32'h1);
    chk("spur_rd_valid", 32'(bif.rd_valid_o), 32'h0);
    chk("spur_rd_data",  32'(bif.rd_data_o),  32'h5555);
    drive_req(0, 16'h50, 16'h0); tick();
    bif.req_valid_i = 0;
    chk("mid_rd_wait", 32'(bif.wait_o), 32'h1);
    rst_n = 0; tick();
    rst_n = 1;
    chk("mid_rst_err",  32'(bif.err_o),  32'h0);
    chk("mid_rst_wait", 32'(bif.wait_o), 32'h0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bif.req_valid_i = 1'($urandom);
      bif.req_write_i = ($urandom_range(0, 9) < 7);
      bif.req_addr_i  = AW'($urandom);
      bif.req_wdata_i = DW'($urandom);
      bif.bus_ready_i = 1'($urandom);
      bif.rsp_valid_i = ($urandom_range(0, 3) == 0);
      bif.rsp_rdata_i = DW'($urandom);
      tick();
    end
    rst_n = 1;
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
